// File: rtl/serial_tx_framer.sv
// serial_tx_framer: serializes one parallel word per frame onto a UART-style TX line.
// Each frame is a start bit, DATA_W data bits sent LSB first, an optional parity bit,
// and STOP_BITS stop bits.
// Ports:
//   clk_i        system clock
//   clr_n_i      asynchronous active-low reset
//   din_i        word to transmit
//   din_valid_i  din_i holds a word
//   din_ready_o  framer can accept a word
//   tick_i       single-cycle bit-period pulse from the bit counter
//   cnt_ce_o     bit counter enable
//   cnt_clr_o    bit counter clear
//   tx_o         serial line, idles high
//   busy_o       frame in progress
//   done_o       one-cycle pulse at frame end
module serial_tx_framer #(
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic              clk_i,
    input  logic              clr_n_i,
    input  logic [DATA_W-1:0] din_i,
    input  logic              din_valid_i,
    output logic              din_ready_o,
    input  logic              tick_i,
    output logic              cnt_ce_o,
    output logic              cnt_clr_o,
    output logic              tx_o,
    output logic              busy_o,
    output logic              done_o
);
    localparam int IW = DATA_W > 1 ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              stop_q, stop_d;
    logic              par_q, par_d;
    logic              tx_q, tx_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ce_q, ce_d;
    logic              clr_q, clr_d;

    always_ff @(posedge clk_i or negedge clr_n_i) begin
        if (!clr_n_i) begin
            state_q <= IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ce_q    <= 1'b0;
            clr_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ce_q    <= ce_d;
            clr_q   <= clr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        stop_d  = stop_q;
        par_d   = par_q;
        tx_d    = tx_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ce_d    = ce_q;
        clr_d   = clr_q;
        case (state_q)
            IDLE: begin
                // Ticks are ignored here; the counter is held clear until accept.
                if (din_valid_i && ready_q) begin
                    shreg_d = din_i;
                    par_d   = (^din_i) ^ (PARITY_ODD != 0);
                    state_d = START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                    clr_d   = 1'b0;
                    ce_d    = 1'b1;
                end
            end
            START: begin
                if (tick_i) begin
                    tx_d    = shreg_q[0];
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (tick_i) begin
                    if (idx_q != IW'(DATA_W - 1)) begin
                        shreg_d = shreg_q >> 1;
                        tx_d    = shreg_d[0];
                        idx_d   = idx_q + 1'b1;
                    end else if (PARITY_EN != 0) begin
                        state_d = PARITY;
                        tx_d    = par_q;
                    end else begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                        stop_d  = 1'b0;
                    end
                end
            end
            PARITY: begin
                if (tick_i) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                    stop_d  = 1'b0;
                end
            end
            STOP: begin
                if (tick_i) begin
                    if (STOP_BITS == 2 && !stop_q) begin
                        stop_d = 1'b1;
                    end else begin
                        // Ready returns on this edge so a new word can be taken next edge.
                        state_d = IDLE;
                        tx_d    = 1'b1;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                        ce_d    = 1'b0;
                        clr_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign tx_o        = tx_q;
    assign din_ready_o = ready_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign cnt_ce_o    = ce_q;
    assign cnt_clr_o   = clr_q;
endmodule

// File: tb/tb_serial_tx_framer.sv
// tb_serial_tx_framer: directed self-checking bench for serial_tx_framer.
// Three instances cover even parity/1 stop, odd parity/2 stops and no parity.
// Each instance gets its own bit-period counter model (10 clocks per bit).
module tb_serial_tx_framer;
    logic       clk   = 1'b0;
    logic       clr_n = 1'b1;
    logic [7:0] din   = 8'h00;
    logic [2:0] vld   = 3'b000;
    logic       ftick = 1'b0;
    logic [2:0] tick, tx, rdy, busy, done, ce, clr;
    int         cnt[3];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk or negedge clr_n) begin
        for (int i = 0; i < 3; i++) begin
            if (!clr_n || clr[i]) cnt[i] <= 0;
            else if (ce[i]) cnt[i] <= (cnt[i] == 9) ? 0 : cnt[i] + 1;
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_tick
        assign tick[g] = ftick | (ce[g] && cnt[g] == 9);
    end

    serial_tx_framer #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
        .clk_i(clk), .clr_n_i(clr_n), .din_i(din), .din_valid_i(vld[0]), .din_ready_o(rdy[0]),
        .tick_i(tick[0]), .cnt_ce_o(ce[0]), .cnt_clr_o(clr[0]), .tx_o(tx[0]), .busy_o(busy[0]),
        .done_o(done[0]));
    serial_tx_framer #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u1 (
        .clk_i(clk), .clr_n_i(clr_n), .din_i(din), .din_valid_i(vld[1]), .din_ready_o(rdy[1]),
        .tick_i(tick[1]), .cnt_ce_o(ce[1]), .cnt_clr_o(clr[1]), .tx_o(tx[1]), .busy_o(busy[1]),
        .done_o(done[1]));
    serial_tx_framer #(.DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u2 (
        .clk_i(clk), .clr_n_i(clr_n), .din_i(din), .din_valid_i(vld[2]), .din_ready_o(rdy[2]),
        .tick_i(tick[2]), .cnt_ce_o(ce[2]), .cnt_clr_o(clr[2]), .tx_o(tx[2]), .busy_o(busy[2]),
        .done_o(done[2]));

    // Sends d on instance u starting from a negedge; s lists the expected TX level per tick period.
    // hold keeps valid high for a back-to-back follow-up; scramble changes din mid-frame.
    task automatic frame(input int u, input logic [7:0] d, input string s, input bit hold,
                         input bit scramble);
        logic [5:0] acc;
        bit ok;
        logic seen_tx, seen_done, seen_rdy;
        din = d;
        vld[u] = 1'b1;
        @(negedge clk);
        if (!(hold || scramble)) vld[u] = 1'b0;
        acc = {tx[u], busy[u], rdy[u], ce[u], clr[u], done[u]};
        checks++;
        if (acc !== 6'b010100) begin
            errors++;
            $display("FAIL accept u%0d: {tx,busy,rdy,ce,clr,done}=%b, expected 010100", u, acc);
        end
        for (int b = 0; b < s.len(); b++) begin
            ok = 1'b1;
            seen_tx = 1'b0;
            seen_done = 1'b0;
            seen_rdy = 1'b0;
            for (int c = 0; c < 10; c++) begin
                if (b > 0 || c > 0) @(negedge clk);
                if (scramble && b == 3 && c == 0) din = ~d;
                if (ok && (tx[u] !== (s[b] == "1") || done[u] !== 1'b0 || rdy[u] !== 1'b0)) begin
                    ok = 1'b0;
                    seen_tx = tx[u];
                    seen_done = done[u];
                    seen_rdy = rdy[u];
                end
            end
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL frame u%0d period %0d: tx=%b done=%b rdy=%b, expected tx=%0d done=0 rdy=0",
                         u, b, seen_tx, seen_done, seen_rdy, (s[b] == "1"));
            end
        end
        @(negedge clk);
        if (!hold) vld[u] = 1'b0;
        acc = {tx[u], busy[u], rdy[u], ce[u], clr[u], done[u]};
        checks++;
        if (acc !== 6'b101011) begin
            errors++;
            $display("FAIL frame end u%0d: {tx,busy,rdy,ce,clr,done}=%b, expected 101011", u, acc);
        end
        if (!hold) begin
            @(negedge clk);
            checks++;
            if (done[u] !== 1'b0 || tx[u] !== 1'b1) begin
                errors++;
                $display("FAIL done pulse u%0d: done=%b tx=%b, expected done=0 tx=1", u, done[u], tx[u]);
            end
        end
    endtask

    task automatic test_reset();
        #2 clr_n = 1'b0;
        #1;
        checks++;
        if ({tx, rdy, busy, done, ce, clr} !== {3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 3'b111}) begin
            errors++;
            $display("FAIL reset async: tx=%b rdy=%b busy=%b done=%b ce=%b clr=%b", tx, rdy, busy, done, ce, clr);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({tx, rdy, busy, done, ce, clr} !== {3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 3'b111}) begin
            errors++;
            $display("FAIL reset held: tx=%b rdy=%b busy=%b done=%b ce=%b clr=%b", tx, rdy, busy, done, ce, clr);
        end
        clr_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({tx, rdy, busy, ce, clr} !== {3'b111, 3'b111, 3'b000, 3'b000, 3'b111}) begin
            errors++;
            $display("FAIL reset release: tx=%b rdy=%b busy=%b ce=%b clr=%b", tx, rdy, busy, ce, clr);
        end
    endtask

    task automatic test_idle_tick();
        ftick = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (tx !== 3'b111 || busy !== 3'b000 || ce !== 3'b000) begin
                errors++;
                $display("FAIL idle tick %0d: tx=%b busy=%b ce=%b, expected 111 000 000", i, tx, busy, ce);
            end
        end
        ftick = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        frame(0, 8'hA5, "01010010101", 1'b0, 1'b0);
    endtask

    task automatic test_odd_two_stop();
        frame(1, 8'h01, "010000000011", 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        frame(2, 8'h3C, "0001111001", 1'b1, 1'b0);
        frame(2, 8'hC3, "0110000111", 1'b0, 1'b0);
    endtask

    task automatic test_ignored_din();
        frame(0, 8'hA5, "01010010101", 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        din = 8'hA5;
        vld[0] = 1'b1;
        @(negedge clk);
        vld[0] = 1'b0;
        repeat (55) @(negedge clk);
        checks++;
        if (tx[0] !== 1'b0 || busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL data bit4: tx=%b busy=%b, expected tx=0 busy=1", tx[0], busy[0]);
        end
        #2 clr_n = 1'b0;
        #1;
        checks++;
        if ({tx[0], busy[0], rdy[0], done[0], ce[0], clr[0]} !== 6'b101001) begin
            errors++;
            $display("FAIL mid-frame reset: {tx,busy,rdy,done,ce,clr}=%b, expected 101001",
                     {tx[0], busy[0], rdy[0], done[0], ce[0], clr[0]});
        end
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done !== 3'b000 || tx !== 3'b111 || rdy !== 3'b111) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL after reset: done=%b tx=%b rdy=%b, expected 000 111 111", done, tx, rdy);
        end
        frame(0, 8'h55, "01010101001", 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_idle_tick();
        test_basic();
        test_odd_two_stop();
        test_back_to_back();
        test_ignored_din();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
